// File: rtl/load_v_arbiter_if.sv
// ----------------------------------------------------------------------------
// load_v_arbiter_if
//   Groups the requester-side and load_v-side signals of load_v_arbiter.
//   Clock and reset stay plain ports on the arbiter itself.
//
//   Requester side:
//     req_valid  [NUM_REQ]      request pending, addr/len held until req_ack
//     req_addr   [NUM_REQ][24]  DRAM start address per requester
//     req_len    [NUM_REQ][10]  length in elements per requester
//     req_ack    [NUM_REQ]      one-cycle pulse, request accepted
//     tile_valid [NUM_REQ]      one-hot, granted requester samples data_out
//     tile_idx   [6]            tile index within the current transfer
//     done       [NUM_REQ]      one-cycle completion pulse
//     grant_id   [IDW]          current or last granted requester
//     busy                      arbiter is not idle
//     err                       sticky error flag
//   load_v side:
//     lv_valid_in, lv_dram_addr[24], lv_length[10]   start command
//     lv_tile_out, lv_valid_out                      tile / completion strobes
//
//   Modport master is the arbiter; modport slave is its environment.
// ----------------------------------------------------------------------------
interface load_v_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][23:0]  req_addr;
  logic [NUM_REQ-1:0][9:0]   req_len;
  logic [NUM_REQ-1:0]        req_ack;

  logic                      lv_valid_in;
  logic [23:0]               lv_dram_addr;
  logic [9:0]                lv_length;
  logic                      lv_tile_out;
  logic                      lv_valid_out;

  logic [NUM_REQ-1:0]        tile_valid;
  logic [5:0]                tile_idx;
  logic [NUM_REQ-1:0]        done;
  logic [IDW-1:0]            grant_id;
  logic                      busy;
  logic                      err;

  modport master (
    input  req_valid, req_addr, req_len, lv_tile_out, lv_valid_out,
    output req_ack, lv_valid_in, lv_dram_addr, lv_length,
           tile_valid, tile_idx, done, grant_id, busy, err
  );

  modport slave (
    output req_valid, req_addr, req_len, lv_tile_out, lv_valid_out,
    input  req_ack, lv_valid_in, lv_dram_addr, lv_length,
           tile_valid, tile_idx, done, grant_id, busy, err
  );
endinterface

// File: rtl/load_v_arbiter.sv
// ----------------------------------------------------------------------------
// load_v_arbiter
//   Round-robin arbiter and sequencer sharing a single load_v vector-load
//   engine between NUM_REQ requesters. One request is served at a time:
//   the arbiter issues the load_v start command, steers each tile strobe
//   back to the granted requester with a tile index, pulses done at the end,
//   and raises a sticky err on tile-count mismatch or a stalled transfer.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high
//     bus   load_v_arbiter_if.master (request, load_v and status signals)
//
//   Parameters:
//     NUM_REQ     number of requesters (2..8)
//     TILE_WIDTH  bits per load_v tile
//     DATA_WIDTH  bits per element
//     TIMEOUT     max cycles between tile strobes before aborting
// ----------------------------------------------------------------------------
module load_v_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int TILE_WIDTH = 256,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  load_v_arbiter_if.master bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMPLETE,
    DRAIN
  } state_e;

  state_e          state_q,  state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q,  grant_d;
  logic [23:0]     addr_q,   addr_d;
  logic [9:0]      len_q,    len_d;
  logic [15:0]     exp_q,    exp_d;
  logic [15:0]     cnt_q,    cnt_d;
  logic [WDW-1:0]  wdog_q,   wdog_d;
  logic            err_q,    err_d;

  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  cand_id;
  logic [9:0]      pick_len;
  logic [31:0]     need_bits;
  logic [15:0]     exp_calc;
  logic [15:0]     cnt_now;

  // Round-robin search starting just after the last grant, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_id = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && bus.req_valid[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  // Expected tile count, rounded up, computed wide so nothing truncates.
  always_comb begin
    pick_len  = bus.req_len[pick_id];
    need_bits = 32'(pick_len) * 32'(DATA_WIDTH) + 32'(TILE_WIDTH - 1);
    exp_calc  = 16'(need_bits / 32'(TILE_WIDTH));
  end

  // Tile count including a strobe arriving this very cycle, so a final
  // strobe coinciding with lv_valid_out is counted before the check.
  assign cnt_now = cnt_q + 16'(bus.lv_tile_out);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    len_d    = len_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          addr_d   = bus.req_addr[pick_id];
          len_d    = pick_len;
          grant_d  = pick_id;
          rr_ptr_d = pick_id;
          exp_d    = exp_calc;
          cnt_d    = '0;
          wdog_d   = '0;
          // Zero-length requests never start load_v.
          state_d  = (pick_len == 10'd0) ? COMPLETE : ISSUE;
        end
      end

      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.lv_tile_out) begin
          cnt_d  = cnt_now;
          wdog_d = '0;
          if (cnt_now > exp_q) begin
            err_d = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end

        // Completion wins over a watchdog expiry in the same cycle.
        if (bus.lv_valid_out) begin
          state_d = COMPLETE;
          if (cnt_now != exp_q) begin
            err_d = 1'b1;
          end
        end else if (!bus.lv_tile_out && wdog_q == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = DRAIN;
        end
      end

      // load_v may still be mid-transfer; hold off any restart until it
      // finishes or a second timeout elapses.
      DRAIN: begin
        if (bus.lv_valid_out || wdog_q == WDW'(TIMEOUT - 1)) begin
          wdog_d  = '0;
          state_d = COMPLETE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      COMPLETE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      grant_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
    end
  end

  // req_ack is gated by rst so no acknowledge escapes while reset is held.
  always_comb begin
    bus.req_ack    = '0;
    bus.tile_valid = '0;
    bus.done       = '0;
    if (state_q == IDLE && pick_found && !rst) begin
      bus.req_ack[pick_id] = 1'b1;
    end
    if (state_q == WAIT && bus.lv_tile_out) begin
      bus.tile_valid[grant_q] = 1'b1;
    end
    if (state_q == COMPLETE) begin
      bus.done[grant_q] = 1'b1;
    end
  end

  assign bus.lv_valid_in  = (state_q == ISSUE);
  assign bus.lv_dram_addr = addr_q;
  assign bus.lv_length    = len_q;
  assign bus.tile_idx     = cnt_q[5:0];
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.err          = err_q;

endmodule
